// File: rtl/instruktion_lader.sv
// instruktion_lader -- boot-time program loader.
//
// Receives a program over an 8N1 UART line and writes it word by word into
// the instruction RAM while holding the CPU in reset. The wire format is a
// 16-bit little-endian word count N, followed by N little-endian 32-bit words.
// When the macro INSTRUKTION_LADER_CHECKSUM_EN is defined, one XOR checksum
// byte over all data bytes follows the words and must match.
//
// Ports:
//   Clock                      system clock, rising edge
//   Reset                      synchronous, active-high reset
//   RxD                        UART receive line (asynchronous, idle high)
//   SchreibenFertig            RAM write acknowledge
//   InstruktionAdresse         word address of the write in progress
//   InstruktionRAMEingang      word to write
//   BeschreibeInstruktionRAM   RAM write enable
//   InstruktionInitialisierung high while the loader owns the RAM address
//   CPUReset                   CPU reset, released when loading completes
//   Fertig                     load completed successfully
//   Fehler                     load aborted (sticky until Reset)
module instruktion_lader #(
  parameter int CLKS_PER_BIT = 217,
  parameter int WORDS        = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RxD,
  input  logic        SchreibenFertig,
  output logic [31:0] InstruktionAdresse,
  output logic [31:0] InstruktionRAMEingang,
  output logic        BeschreibeInstruktionRAM,
  output logic        InstruktionInitialisierung,
  output logic        CPUReset,
  output logic        Fertig,
  output logic        Fehler
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]     WORDS_L   = 17'(WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef enum logic [2:0] {
    LAENGE, DATEN, SCHREIBEN, FERTIG, FEHLER
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
    , PRUEFSUMME
`endif
  } state_e;

  // ---------------- receiver ----------------
  rx_state_e     rx_state_q, rx_state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next state: mid-bit sampling, LSB first, stop bit checked.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          // A start bit that is high again at mid-bit was only a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------- loader ----------------
  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        in_valid_s;
  logic [7:0]  in_byte_s;
  logic [15:0] len_full_s;
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  // Loader next state: byte feed, length/word assembly, write handshake.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    asm_d        = asm_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    in_valid_s   = 1'b0;
    in_byte_s    = 8'h00;
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    // A byte parked during a write is consumed first; a byte arriving in the
    // same cycle takes its place in the holding register.
    if (hold_valid_q) begin
      in_valid_s   = 1'b1;
      in_byte_s    = hold_q;
      hold_valid_d = rx_valid_q;
      hold_d       = rx_valid_q ? rx_shift_q : hold_q;
    end else begin
      in_valid_s   = rx_valid_q;
      in_byte_s    = rx_shift_q;
    end
    len_full_s = {in_byte_s, len_q[7:0]};

    if (rx_ferr_q && (state_q != FERTIG) && (state_q != FEHLER)) begin
      state_d = FEHLER;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        LAENGE: begin
          if (in_valid_s && (byte_cnt_q == 2'd0)) begin
            len_d      = {8'h00, in_byte_s};
            byte_cnt_d = 2'd1;
          end else if (in_valid_s) begin
            len_d      = len_full_s;
            byte_cnt_d = 2'd0;
            if (len_full_s == 16'h0000) begin
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
              state_d = PRUEFSUMME;
`else
              state_d = FERTIG;
`endif
            end else if ({1'b0, len_full_s} > WORDS_L) begin
              state_d = FEHLER;
            end else begin
              state_d = DATEN;
            end
          end else begin
            state_d = LAENGE;
          end
        end
        DATEN: begin
          if (in_valid_s) begin
            asm_d = {in_byte_s, asm_q[31:8]};
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
            xor_d = xor_q ^ in_byte_s;
`endif
            if (byte_cnt_q == 2'd3) begin
              data_d     = {in_byte_s, asm_q[31:8]};
              we_d       = 1'b1;
              byte_cnt_d = 2'd0;
              state_d    = SCHREIBEN;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end else begin
            state_d = DATEN;
          end
        end
        SCHREIBEN: begin
          if (rx_valid_q && hold_valid_q) begin
            // Second byte before the write finished: overrun.
            state_d = FEHLER;
            we_d    = 1'b0;
          end else begin
            hold_valid_d = hold_valid_q | rx_valid_q;
            hold_d       = rx_valid_q ? rx_shift_q : hold_q;
            if (SchreibenFertig) begin
              we_d = 1'b0;
              if ((addr_q + 32'd1) == {16'h0000, len_q}) begin
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
                state_d = PRUEFSUMME;
`else
                state_d = FERTIG;
`endif
              end else begin
                addr_d  = addr_q + 32'd1;
                state_d = DATEN;
              end
            end else begin
              we_d = 1'b1;
            end
          end
        end
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
        PRUEFSUMME: begin
          if (in_valid_s) begin
            state_d = (in_byte_s == xor_q) ? FERTIG : FEHLER;
          end else begin
            state_d = PRUEFSUMME;
          end
        end
`endif
        FERTIG:  state_d = FERTIG;
        FEHLER:  state_d = FEHLER;
        default: begin
          state_d = FEHLER;
          we_d    = 1'b0;
        end
      endcase
    end
  end

  // Loader state registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= LAENGE;
      byte_cnt_q   <= 2'd0;
      len_q        <= 16'h0000;
      asm_q        <= 32'h0000_0000;
      addr_q       <= 32'h0000_0000;
      data_q       <= 32'h0000_0000;
      we_q         <= 1'b0;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
      xor_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  // All outputs are registers or decodes of the state register.
  assign InstruktionAdresse         = addr_q;
  assign InstruktionRAMEingang      = data_q;
  assign BeschreibeInstruktionRAM   = we_q;
  assign InstruktionInitialisierung = (state_q != FERTIG);
  assign CPUReset                   = (state_q != FERTIG);
  assign Fertig                     = (state_q == FERTIG);
  assign Fehler                     = (state_q == FEHLER);

endmodule

// File: tb/tb_instruktion_lader.sv
// Self-checking bench for instruktion_lader: directed scenarios plus random
// programs, checked against a byte-stream reference model of the protocol.
module tb_instruktion_lader;

  localparam int CPB   = 4;
  localparam int WORDS = 256;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        RxD = 1'b1;
  logic        SchreibenFertig = 1'b0;
  logic [31:0] InstruktionAdresse;
  logic [31:0] InstruktionRAMEingang;
  logic        BeschreibeInstruktionRAM;
  logic        InstruktionInitialisierung;
  logic        CPUReset;
  logic        Fertig;
  logic        Fehler;

  instruktion_lader #(.CLKS_PER_BIT(CPB), .WORDS(WORDS)) dut (
    .Clock                      (Clock),
    .Reset                      (Reset),
    .RxD                        (RxD),
    .SchreibenFertig            (SchreibenFertig),
    .InstruktionAdresse         (InstruktionAdresse),
    .InstruktionRAMEingang      (InstruktionRAMEingang),
    .BeschreibeInstruktionRAM   (BeschreibeInstruktionRAM),
    .InstruktionInitialisierung (InstruktionInitialisierung),
    .CPUReset                   (CPUReset),
    .Fertig                     (Fertig),
    .Fehler                     (Fehler)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // RAM model: acknowledge one cycle after write-enable, log completed writes.
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          we_cycles = 0;
  int          unstable = 0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_data = 32'h0;

  always @(posedge Clock) begin
    SchreibenFertig <= BeschreibeInstruktionRAM && !SchreibenFertig;
    if (BeschreibeInstruktionRAM) we_cycles <= we_cycles + 1;
    if (BeschreibeInstruktionRAM && SchreibenFertig && !Reset) begin
      wr_addr_log.push_back(InstruktionAdresse);
      wr_data_log.push_back(InstruktionRAMEingang);
    end
    if (prev_we && BeschreibeInstruktionRAM &&
        ((InstruktionAdresse != prev_addr) || (InstruktionRAMEingang != prev_data)))
      unstable <= unstable + 1;
    prev_we   <= BeschreibeInstruktionRAM;
    prev_addr <= InstruktionAdresse;
    prev_data <= InstruktionRAMEingang;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int idle_bits);
    RxD = 1'b0;
    repeat (CPB) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge Clock);
    end
    RxD = stop;
    repeat (CPB) @(negedge Clock);
    RxD = 1'b1;
    repeat (CPB * idle_bits) @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  // Reference model: expected writes and final status for a byte stream in
  // which the byte at index 'bad' (if any) carries a low stop bit.
  logic [31:0] exp_wr[$];

  function automatic void model_run(input logic [7:0] s[$], input int bad,
                                    output bit ok, output bit err);
    int n;
    logic [7:0] x;
    exp_wr.delete();
    ok = 1'b0;
    err = 1'b0;
    x = 8'h00;
    if (bad == 0 || bad == 1) begin err = 1'b1; return; end
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > WORDS) begin err = 1'b1; return; end
    for (int w = 0; w < n; w++) begin
      logic [31:0] wd;
      wd = 32'h0;
      for (int b = 0; b < 4; b++) begin
        int i;
        i = 2 + 4 * w + b;
        if (i == bad) begin err = 1'b1; return; end
        wd = wd | (32'(s[i]) << (8 * b));
        x = x ^ s[i];
      end
      exp_wr.push_back(wd);
    end
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
    if (bad == 2 + 4 * n) begin err = 1'b1; return; end
    if (s[2 + 4 * n] != x) begin err = 1'b1; return; end
`endif
    ok = 1'b1;
  endfunction

  // Build a well-formed stream (length, words, checksum when enabled).
  function automatic void build_prog(input logic [31:0] w[$], output logic [7:0] s[$]);
    logic [7:0] x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(w.size());
    s.delete();
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    foreach (w[k]) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] v;
        v = 8'(w[k] >> (8 * b));
        s.push_back(v);
        x = x ^ v;
      end
    end
`ifdef INSTRUKTION_LADER_CHECKSUM_EN
    s.push_back(x);
`endif
  endfunction

  // Send a stream, wait for a terminal state and compare against the model.
  task automatic run_stream(input string tag, input logic [7:0] s[$], input int bad);
    bit ok, err;
    int base, n, we0;
    base = wr_addr_log.size();
    we0  = we_cycles;
    model_run(s, bad, ok, err);
    foreach (s[i]) send_byte(s[i], (i != bad), 1);
    n = 0;
    while (!(Fertig || Fehler) && n < 400) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 400), 32'd1);
    repeat (2) @(negedge Clock);
    chk({tag, "_fertig"}, 32'(Fertig), 32'(ok));
    chk({tag, "_fehler"}, 32'(Fehler), 32'(err));
    chk({tag, "_cpureset"}, 32'(CPUReset), 32'(!ok));
    chk({tag, "_init"}, 32'(InstruktionInitialisierung), 32'(!ok));
    chk({tag, "_nwrites"}, 32'(wr_addr_log.size() - base), 32'(exp_wr.size()));
    if (exp_wr.size() == 0) chk({tag, "_no_we"}, 32'(we_cycles - we0), 32'd0);
    else chk({tag, "_we_seen"}, 32'(we_cycles - we0 > 0), 32'd1);
    for (int k = 0; k < exp_wr.size() && base + k < wr_addr_log.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), wr_addr_log[base + k], 32'(k));
      chk($sformatf("%s_data%0d", tag, k), wr_data_log[base + k], exp_wr[k]);
    end
  endtask

  initial begin
    logic [7:0]  s[$];
    logic [31:0] w[$];
    int n;

    // Reset values.
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_addr", InstruktionAdresse, 32'h0);
    chk("rst_data", InstruktionRAMEingang, 32'h0);
    chk("rst_we", 32'(BeschreibeInstruktionRAM), 32'd0);
    chk("rst_init", 32'(InstruktionInitialisierung), 32'd1);
    chk("rst_cpureset", 32'(CPUReset), 32'd1);
    chk("rst_fertig", 32'(Fertig), 32'd0);
    chk("rst_fehler", 32'(Fehler), 32'd0);

    // Directed two-word program.
    w = '{32'hDEADBEEF, 32'h00000013};
    build_prog(w, s);
    run_stream("two_words", s, -1);

    // Length 257 exceeds WORDS.
    do_reset();
    s = '{8'h01, 8'h01};
    run_stream("too_long", s, -1);

    // Low stop bit on the 3rd data byte.
    do_reset();
    build_prog(w, s);
    run_stream("stop_err", s, 4);

    // One-cycle glitch in idle must not be taken as a byte.
    do_reset();
    n = we_cycles;
    RxD = 1'b0;
    @(negedge Clock);
    RxD = 1'b1;
    repeat (30) @(negedge Clock);
    chk("glitch_fehler", 32'(Fehler), 32'd0);
    chk("glitch_fertig", 32'(Fertig), 32'd0);
    chk("glitch_cpureset", 32'(CPUReset), 32'd1);
    chk("glitch_no_we", 32'(we_cycles - n), 32'd0);
    run_stream("after_glitch", s, -1);

    // Reset while the second word is being written.
    do_reset();
    build_prog(w, s);
    for (int i = 0; i < 9; i++) send_byte(s[i], 1'b1, 1);
    send_byte(s[9], 1'b1, 0);
    n = 0;
    while (!BeschreibeInstruktionRAM && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("midwr_we_seen", 32'(BeschreibeInstruktionRAM), 32'd1);
    chk("midwr_addr1", InstruktionAdresse, 32'd1);
    chk("midwr_data1", InstruktionRAMEingang, 32'h00000013);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("midwr_we_drop", 32'(BeschreibeInstruktionRAM), 32'd0);
    chk("midwr_addr0", InstruktionAdresse, 32'd0);
    chk("midwr_cpureset", 32'(CPUReset), 32'd1);
    chk("midwr_fehler", 32'(Fehler), 32'd0);
    @(negedge Clock);
    run_stream("after_midwr", s, -1);

    // Empty program.
    do_reset();
    w.delete();
    build_prog(w, s);
    run_stream("len0", s, -1);

`ifdef INSTRUKTION_LADER_CHECKSUM_EN
    // Wrong checksum.
    do_reset();
    s = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run_stream("bad_sum", s, -1);
`endif

    // Random programs, one with a random bad stop bit.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      w.delete();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) w.push_back($urandom);
      build_prog(w, s);
      run_stream($sformatf("rand%0d", r), s, (r == 4) ? int'($urandom_range(0, s.size() - 1)) : -1);
    end

    chk("we_stable", 32'(unstable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
